// File: rtl/ufm_hexdump_if.sv
// Byte-in / character-out bus between ufm_reader, the hex formatter and the uart.
interface ufm_hexdump_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       frame_done;

    // Byte source / character sink side
    modport master (
        output in_data, in_valid, tx_ready,
        input  in_ready, tx_data, tx_valid, frame_done
    );

    // Formatter side
    modport slave (
        input  in_data, in_valid, tx_ready,
        output in_ready, tx_data, tx_valid, frame_done
    );
endinterface

// File: rtl/ufm_hexdump.sv
// Formats the UFM byte stream into "AAAA: XX XX ...\r\n" lines for the uart,
// with a blank line and a frame_done pulse after every frame.
module ufm_hexdump #(
    parameter logic [14:0] START_ADDR     = 15'd32672,
    parameter int unsigned SIZE           = 64,
    parameter int unsigned BYTES_PER_LINE = 16
) (
    input  logic         clk,
    input  logic         rst,
    ufm_hexdump_if.slave bus
);
    localparam int unsigned AW = 15;
    localparam int unsigned LW = 5;
    localparam int unsigned NW = 3;

    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

    typedef enum logic [3:0] {
        ADDR, WAIT_BYTE, SP, HI, LO, CR, LF, BCR, BLF
    } state_t;

    state_t          state, state_n;
    logic [NW-1:0]   nib, nib_n;
    logic [AW-1:0]   line_addr, line_addr_n;
    logic [AW-1:0]   byte_cnt, byte_cnt_n;
    logic [LW-1:0]   line_cnt, line_cnt_n;
    logic [7:0]      data_q, data_n;
    logic [7:0]      tx_data_q, tx_data_n;
    logic            tx_valid_q, tx_valid_n;
    logic            frame_done_q, frame_done_n;
    logic            tx_fire;
    logic            frame_full;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character presented while sitting in state s
    function automatic logic [7:0] char_for(input state_t s, input logic [NW-1:0] ni,
                                            input logic [AW-1:0] a, input logic [7:0] d);
        logic [15:0] a16;
        logic [7:0]  c;
        a16 = {1'b0, a};
        c   = 8'h00;
        case (s)
            ADDR: begin
                case (ni)
                    3'd0:    c = hex_char(a16[15:12]);
                    3'd1:    c = hex_char(a16[11:8]);
                    3'd2:    c = hex_char(a16[7:4]);
                    3'd3:    c = hex_char(a16[3:0]);
                    default: c = CH_COLON;
                endcase
            end
            SP:       c = CH_SP;
            HI:       c = hex_char(d[7:4]);
            LO:       c = hex_char(d[3:0]);
            CR, BCR:  c = CH_CR;
            LF, BLF:  c = CH_LF;
            default:  c = 8'h00;
        endcase
        return c;
    endfunction

    assign tx_fire        = tx_valid_q && bus.tx_ready;
    assign frame_full     = (byte_cnt == AW'(SIZE));
    assign bus.in_ready   = (state == WAIT_BYTE);
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.frame_done = frame_done_q;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ADDR;
            nib          <= '0;
            line_addr    <= START_ADDR;
            byte_cnt     <= '0;
            line_cnt     <= '0;
            data_q       <= '0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_n;
            nib          <= nib_n;
            line_addr    <= line_addr_n;
            byte_cnt     <= byte_cnt_n;
            line_cnt     <= line_cnt_n;
            data_q       <= data_n;
            tx_data_q    <= tx_data_n;
            tx_valid_q   <= tx_valid_n;
            frame_done_q <= frame_done_n;
        end
    end

    // Next state, counters, and the character to present next cycle
    always_comb begin
        state_n      = state;
        nib_n        = nib;
        line_addr_n  = line_addr;
        byte_cnt_n   = byte_cnt;
        line_cnt_n   = line_cnt;
        data_n       = data_q;
        frame_done_n = 1'b0;
        tx_data_n    = tx_data_q;
        tx_valid_n   = tx_valid_q;

        if (state == WAIT_BYTE) begin
            if (bus.in_valid) begin
                data_n     = bus.in_data;
                byte_cnt_n = byte_cnt + AW'(1);
                line_cnt_n = line_cnt + LW'(1);
                state_n    = SP;
            end
        end else if (tx_fire) begin
            case (state)
                ADDR: begin
                    if (nib == NW'(4)) begin
                        nib_n   = '0;
                        state_n = WAIT_BYTE;
                    end else begin
                        nib_n = nib + NW'(1);
                    end
                end
                SP: state_n = HI;
                HI: state_n = LO;
                LO: begin
                    if (frame_full || (line_cnt == LW'(BYTES_PER_LINE))) begin
                        state_n = CR;
                    end else begin
                        state_n = WAIT_BYTE;
                    end
                end
                CR: state_n = LF;
                LF: begin
                    line_cnt_n = '0;
                    if (frame_full) begin
                        state_n = BCR;
                    end else begin
                        line_addr_n = line_addr + AW'(BYTES_PER_LINE);
                        state_n     = ADDR;
                    end
                end
                BCR: state_n = BLF;
                BLF: begin
                    frame_done_n = 1'b1;
                    line_addr_n  = START_ADDR;
                    byte_cnt_n   = '0;
                    state_n      = ADDR;
                end
                default: state_n = ADDR;
            endcase
        end

        // Reload the character register whenever it is empty or just transferred
        if (!tx_valid_q || tx_fire) begin
            tx_valid_n = (state_n != WAIT_BYTE);
            if (tx_valid_n) begin
                tx_data_n = char_for(state_n, nib_n, line_addr_n, data_n);
            end
        end
    end
endmodule

// File: tb/tb_ufm_hexdump.sv
// Randomized bench for ufm_hexdump: two instances (full and partial last line)
// checked against a string-level model of the dump format.
module tb_ufm_hexdump;
    logic clk;
    logic rst_a;
    logic rst_b;

    int checks = 0;
    int errors = 0;

    ufm_hexdump_if ia ();
    ufm_hexdump_if ib ();

    ufm_hexdump #(.START_ADDR(15'h7FA0), .SIZE(4), .BYTES_PER_LINE(2)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia)
    );

    ufm_hexdump #(.START_ADDR(15'h7FA0), .SIZE(3), .BYTES_PER_LINE(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] hx(input int v);
        string digits;
        digits = "0123456789ABCDEF";
        return digits[v & 15];
    endfunction

    // Full character stream of one frame, blank line included
    function automatic void frame_chars(input int start, input int size, input int bpl,
                                        input logic [7:0] d[$], output logic [7:0] c[$]);
        int a;
        c = {};
        for (int i = 0; i < size; i += bpl) begin
            a = (start + i) % 32768;
            for (int k = 3; k >= 0; k--) c.push_back(hx(a >> (4 * k)));
            c.push_back(":");
            for (int j = i; j < i + bpl && j < size; j++) begin
                c.push_back(" ");
                c.push_back(hx(int'(d[j]) >> 4));
                c.push_back(hx(int'(d[j])));
            end
            c.push_back(8'h0D);
            c.push_back(8'h0A);
        end
        c.push_back(8'h0D);
        c.push_back(8'h0A);
    endfunction

    // ---------------- instance A driver / monitor ----------------
    logic [7:0]  src_a[$];
    logic [7:0]  exp_a[$];
    bit          end_a[$];
    int unsigned in_rate  = 100;
    int unsigned rdy_rate = 100;
    bit          fd_pend  = 0;
    bit          stall_prev = 0;
    logic [7:0]  prev_data = 8'h00;
    bit          chk_idle = 0;
    bit          want_accept = 0;
    bit          obs_ready = 0;
    int          ntx_a = 0;
    int          fd_cnt_a = 0;
    int          fd_exp_a = 0;
    bit          done_b = 0;

    task automatic push_frame_a(input logic [7:0] d[$]);
        logic [7:0] c[$];
        frame_chars(32'h7FA0, 4, 2, d, c);
        foreach (d[i]) src_a.push_back(d[i]);
        foreach (c[i]) begin
            exp_a.push_back(c[i]);
            end_a.push_back(i == c.size() - 1);
        end
    endtask

    // One clock: observe at negedge, drive #1 after the posedge
    task automatic cycle_a();
        logic [7:0] c;
        bit         e;
        bit         acc;
        @(negedge clk);
        check("frame_done", ia.frame_done, fd_pend);
        if (ia.frame_done) fd_cnt_a++;
        if (stall_prev) check("stall_hold", {ia.tx_valid, ia.tx_data}, {1'b1, prev_data});
        if (chk_idle) begin
            check("idle_in_ready", ia.in_ready, 1);
            check("idle_tx_valid", ia.tx_valid, 0);
        end
        if (want_accept && ia.in_valid) begin
            check("first_accept", ia.in_ready, 1);
            want_accept = 0;
        end
        fd_pend = 0;
        if (ia.tx_valid && ia.tx_ready) begin
            if (exp_a.size() == 0) begin
                check("tx_unexpected", 1, 0);
            end else begin
                c = exp_a.pop_front();
                e = end_a.pop_front();
                check("tx_char", ia.tx_data, c);
                fd_pend = e;
                if (e) fd_exp_a++;
                ntx_a++;
            end
        end
        stall_prev = ia.tx_valid && !ia.tx_ready;
        prev_data  = ia.tx_data;
        obs_ready  = ia.in_ready;
        acc = ia.in_valid && ia.in_ready;
        if (acc && src_a.size() > 0) void'(src_a.pop_front());
        @(posedge clk);
        #1;
        if (!(ia.in_valid && !acc)) begin
            ia.in_valid = (src_a.size() > 0) && ($urandom_range(99) < in_rate);
            ia.in_data  = ia.in_valid ? src_a[0] : 8'($urandom);
        end
        ia.tx_ready = (exp_a.size() > 0) && ($urandom_range(99) < rdy_rate);
    endtask

    task automatic drain_a(input int budget);
        int n;
        n = 0;
        while (exp_a.size() > 0 && n < budget) begin
            cycle_a();
            n++;
        end
        check("drain_timeout", exp_a.size(), 0);
        cycle_a();
    endtask

    // Synchronous reset of instance A; called #1 after a posedge
    task automatic do_reset_a();
        rst_a       = 1'b1;
        ia.in_valid = 1'b0;
        ia.tx_ready = 1'b0;
        @(posedge clk);
        #1;
        check("rst_tx_valid", ia.tx_valid, 0);
        check("rst_in_ready", ia.in_ready, 0);
        check("rst_frame_done", ia.frame_done, 0);
        check("rst_tx_data", ia.tx_data, 8'h00);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        src_a = {};
        exp_a = {};
        end_a = {};
        fd_pend    = 0;
        stall_prev = 0;
    endtask

    initial begin
        logic [7:0] d[$];
        int         n;
        ia.in_data  = 8'h00;
        ia.in_valid = 1'b0;
        ia.tx_ready = 1'b0;
        rst_a       = 1'b1;
        do_reset_a();

        // Fixed bytes, full rate, two frames back to back
        d = {8'h00, 8'hAB, 8'h5F, 8'hFF};
        push_frame_a(d);
        push_frame_a(d);
        drain_a(400);

        // Same bytes with a random uart back-pressure
        rdy_rate = 50;
        push_frame_a(d);
        drain_a(600);

        // Random bytes, random source gaps and back-pressure
        in_rate = 60;
        for (int f = 0; f < 4; f++) begin
            d = {};
            repeat (4) d.push_back(8'($urandom));
            push_frame_a(d);
        end
        drain_a(3000);

        // Source withheld once the address and ':' are out
        in_rate  = 0;
        rdy_rate = 100;
        d = {8'h12, 8'h9C, 8'hE0, 8'h07};
        push_frame_a(d);
        n = 0;
        while (!obs_ready && n < 100) begin
            cycle_a();
            n++;
        end
        check("reach_wait_byte", obs_ready, 1);
        chk_idle = 1;
        repeat (20) cycle_a();
        chk_idle    = 0;
        in_rate     = 100;
        want_accept = 1;
        cycle_a();
        cycle_a();
        check("accept_seen", want_accept, 0);
        drain_a(400);

        // Reset after "7FA0: 0", then a clean frame from the start
        d = {8'h0F, 8'h31, 8'hC4, 8'h8A};
        push_frame_a(d);
        ntx_a = 0;
        n = 0;
        while (ntx_a < 7 && n < 200) begin
            cycle_a();
            n++;
        end
        check("pre_reset_chars", ntx_a, 7);
        do_reset_a();
        d = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        push_frame_a(d);
        drain_a(400);
        repeat (3) cycle_a();
        check("frame_done_count", fd_cnt_a, fd_exp_a);
        check("frames_completed", fd_exp_a, 9);

        n = 0;
        while (!done_b && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("b_finished", done_b, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // ---------------- instance B: partial last line ----------------
    initial begin
        logic [7:0] bytes_b[$];
        logic [7:0] c[$];
        logic [7:0] expb[$];
        int         idx;
        int         n;
        int         fd_b;
        bit         acc;
        bytes_b  = {8'h00, 8'hAB, 8'h5F};
        rst_b    = 1'b1;
        ib.in_valid = 1'b0;
        ib.in_data  = 8'h00;
        ib.tx_ready = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        frame_chars(32'h7FA0, 3, 2, bytes_b, c);
        expb = {c, c};
        idx  = 0;
        fd_b = 0;
        n    = 0;
        ib.tx_ready = 1'b1;
        ib.in_valid = 1'b1;
        ib.in_data  = bytes_b[0];
        while (expb.size() > 0 && n < 500) begin
            @(negedge clk);
            if (ib.frame_done) fd_b++;
            if (ib.tx_valid && ib.tx_ready) check("b_char", ib.tx_data, expb.pop_front());
            acc = ib.in_valid && ib.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx = (idx + 1) % 3;
                ib.in_data = bytes_b[idx];
            end
            if (expb.size() == 0) ib.tx_ready = 1'b0;
            n++;
        end
        check("b_drain", expb.size(), 0);
        @(negedge clk);
        if (ib.frame_done) fd_b++;
        check("b_frame_done_count", fd_b, 2);
        done_b = 1;
    end

    // Bounded run time
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", checks);
        $fatal(1, "watchdog expired");
    end
endmodule
